// File: rtl/st7789_pkg.sv
// ST7789 command set and decoder types shared by the LCD driver cores and the
// display-side receiver.
package st7789_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  // Which byte of a two-byte pixel the next RAMWR data byte is.
  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampled SPI byte receiver: pin synchronizers, spi_clk edge detect,
// bit counter and shift register. One-clk byte strobe with value and dc.
module spi_byte_rx #(
  parameter int c_clk_polarity  = 1,
  parameter int c_sample_rising = 1
) (
  input  logic       clk,
  input  logic       resn,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_resn,
  output logic       byte_stb,
  output logic [7:0] byte_val,
  output logic       byte_dc,
  output logic       soft_resn
);

  localparam logic CLK_IDLE = (c_clk_polarity != 0);

  logic [1:0] csn_sr, clk_sr, mosi_sr, dc_sr, resn_sr;
  logic       clk_d, csn_d;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       sample, active;

  // csn_d keeps the 8th edge valid when csn rises in the same clk.
  always_comb begin
    sample = (c_sample_rising != 0) ? (clk_sr[1] & ~clk_d) : (~clk_sr[1] & clk_d);
    active = ~csn_sr[1] | ~csn_d;
  end

  assign soft_resn = resn_sr[1];

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      csn_sr   <= '1;
      clk_sr   <= {2{CLK_IDLE}};
      mosi_sr  <= '0;
      dc_sr    <= '0;
      resn_sr  <= '1;
      clk_d    <= CLK_IDLE;
      csn_d    <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_stb <= 1'b0;
      byte_val <= '0;
      byte_dc  <= 1'b0;
    end else begin
      csn_sr   <= {csn_sr[0], spi_csn};
      clk_sr   <= {clk_sr[0], spi_clk};
      mosi_sr  <= {mosi_sr[0], spi_mosi};
      dc_sr    <= {dc_sr[0], spi_dc};
      resn_sr  <= {resn_sr[0], spi_resn};
      clk_d    <= clk_sr[1];
      csn_d    <= csn_sr[1];
      byte_stb <= 1'b0;
      if (!resn_sr[1]) begin
        bit_cnt <= '0;
      end else if (sample && active) begin
        shreg   <= {shreg[5:0], mosi_sr[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_stb <= 1'b1;
          byte_val <= {shreg, mosi_sr[1]};
          byte_dc  <= dc_sr[1];
        end
      end else if (csn_sr[1]) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/st7789_spi_rx.sv
// ST7789 display emulator front end: decodes the 4-wire write stream into
// command strobes and addressed pixel writes with CASET/RASET windowing.
module st7789_spi_rx
  import st7789_pkg::*;
#(
  parameter int c_x_size        = 240,
  parameter int c_y_size        = 240,
  parameter int c_x_bits        = $clog2(c_x_size),
  parameter int c_y_bits        = $clog2(c_y_size),
  parameter int c_color_bits    = 16,
  parameter int c_clk_polarity  = 1,
  parameter int c_sample_rising = 1
) (
  input  logic                    clk,
  input  logic                    resn,
  input  logic                    spi_csn,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_dc,
  input  logic                    spi_resn,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    pix_we,
  output logic [c_x_bits-1:0]     pix_x,
  output logic [c_y_bits-1:0]     pix_y,
  output logic [c_color_bits-1:0] pix_data
);

  localparam logic [c_x_bits-1:0] X_LAST = c_x_bits'(c_x_size - 1);
  localparam logic [c_y_bits-1:0] Y_LAST = c_y_bits'(c_y_size - 1);

  logic                byte_stb, byte_dc, soft_resn;
  logic [7:0]          byte_val;
  logic [c_x_bits-1:0] xs, xe, px, nx;
  logic [c_y_bits-1:0] ys, ye, py, ny;
  logic [7:0]          cmd, arg_hi, pix_hi;
  logic [3:0]          arg_cnt;
  phase_t              phase;
  logic [15:0]         arg_word, pix_word;
  logic                pix_done;

  spi_byte_rx #(
    .c_clk_polarity (c_clk_polarity),
    .c_sample_rising(c_sample_rising)
  ) u_byte_rx (
    .clk      (clk),
    .resn     (resn),
    .spi_csn  (spi_csn),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc),
    .spi_resn (spi_resn),
    .byte_stb (byte_stb),
    .byte_val (byte_val),
    .byte_dc  (byte_dc),
    .soft_resn(soft_resn)
  );

  always_comb begin
    arg_word = {arg_hi, byte_val};
    pix_word = (c_color_bits >= 12) ? {pix_hi, byte_val} : {8'h00, byte_val};
    pix_done = (c_color_bits < 12) || (phase == PH_LO);
    nx = px + c_x_bits'(1);
    ny = py;
    if (px == xe || px == X_LAST) begin
      nx = xs;
      ny = (py == ye || py == Y_LAST) ? ys : py + c_y_bits'(1);
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      pix_we    <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      xs        <= '0;
      xe        <= X_LAST;
      ys        <= '0;
      ye        <= Y_LAST;
      px        <= '0;
      py        <= '0;
      cmd       <= CMD_NOP;
      arg_hi    <= '0;
      pix_hi    <= '0;
      arg_cnt   <= '0;
      phase     <= PH_HI;
    end else begin
      cmd_valid <= 1'b0;
      pix_we    <= 1'b0;
      if (!soft_resn) begin
        xs      <= '0;
        xe      <= X_LAST;
        ys      <= '0;
        ye      <= Y_LAST;
        cmd     <= CMD_NOP;
        arg_cnt <= '0;
        phase   <= PH_HI;
      end else if (byte_stb && !byte_dc) begin
        // Any command byte also drops a half-received pixel.
        cmd       <= byte_val;
        arg_cnt   <= '0;
        phase     <= PH_HI;
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_val;
        if (byte_val == CMD_RAMWR) begin
          px <= xs;
          py <= ys;
        end
        if (byte_val == CMD_SWRESET) begin
          xs <= '0;
          xe <= X_LAST;
          ys <= '0;
          ye <= Y_LAST;
        end
      end else if (byte_stb) begin
        if (arg_cnt != 4'hF) arg_cnt <= arg_cnt + 4'd1;
        case (cmd)
          CMD_CASET: begin
            case (arg_cnt)
              4'd0, 4'd2: arg_hi <= byte_val;
              4'd1:       xs     <= c_x_bits'(arg_word);
              4'd3:       xe     <= c_x_bits'(arg_word);
              default:    ;
            endcase
          end
          CMD_RASET: begin
            case (arg_cnt)
              4'd0, 4'd2: arg_hi <= byte_val;
              4'd1:       ys     <= c_y_bits'(arg_word);
              4'd3:       ye     <= c_y_bits'(arg_word);
              default:    ;
            endcase
          end
          CMD_RAMWR: begin
            if (pix_done) begin
              pix_we   <= 1'b1;
              pix_x    <= px;
              pix_y    <= py;
              pix_data <= c_color_bits'(pix_word);
              px       <= nx;
              py       <= ny;
              phase    <= PH_HI;
            end else begin
              pix_hi <= byte_val;
              phase  <= PH_LO;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_st7789_spi_rx.sv
// Bench for st7789_spi_rx on a reduced 18x10 panel: table vectors, corner
// sequences and a randomized byte stream against a rule-level display model.
module tb_st7789_spi_rx;

  localparam int XSZ = 18;
  localparam int YSZ = 10;
  localparam int XB  = $clog2(XSZ);
  localparam int YB  = $clog2(YSZ);
  localparam int H   = 4;

  logic          clk = 1'b0;
  logic          resn = 1'b0;
  logic          spi_csn = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0, spi_dc = 1'b0, spi_resn = 1'b1;
  logic          cmd_valid, pix_we;
  logic [7:0]    cmd_byte;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic [15:0]   pix_data;

  st7789_spi_rx #(
    .c_x_size(XSZ),
    .c_y_size(YSZ),
    .c_color_bits(16),
    .c_clk_polarity(1),
    .c_sample_rising(1)
  ) dut (
    .clk(clk), .resn(resn), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_resn(spi_resn), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; } pix_t;
  pix_t got_pix[$];
  int   got_cmd[$];

  always @(negedge clk) begin
    if (cmd_valid) got_cmd.push_back(int'(cmd_byte));
    if (pix_we) got_pix.push_back('{int'(pix_x), int'(pix_y), int'(pix_data)});
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Display model state: window, current command, argument list, write pointer.
  int m_xs, m_xe, m_ys, m_ye, m_cmd, m_arg, m_hi, m_px, m_py;
  bit m_have_hi;
  int m_args[4];
  int e_kind, e_x, e_y, e_d;
  int cap_kind, cap_x, cap_y, cap_d;

  function automatic void m_window_reset();
    m_xs = 0; m_xe = XSZ - 1; m_ys = 0; m_ye = YSZ - 1;
  endfunction

  function automatic void m_reset();
    m_window_reset();
    m_cmd = 0; m_arg = 0; m_have_hi = 0;
  endfunction

  function automatic void m_byte(input bit dc, input int b);
    e_kind = 0;
    if (!dc) begin
      m_cmd = b; m_arg = 0; m_have_hi = 0;
      e_kind = 1; e_d = b;
      if (b == 'h2C) begin m_px = m_xs; m_py = m_ys; end
      if (b == 'h01) m_window_reset();
    end else begin
      if (m_arg < 4) m_args[m_arg] = b;
      if (m_cmd == 'h2A && m_arg == 1) m_xs = (m_args[0] * 256 + b) % (1 << XB);
      if (m_cmd == 'h2A && m_arg == 3) m_xe = (m_args[2] * 256 + b) % (1 << XB);
      if (m_cmd == 'h2B && m_arg == 1) m_ys = (m_args[0] * 256 + b) % (1 << YB);
      if (m_cmd == 'h2B && m_arg == 3) m_ye = (m_args[2] * 256 + b) % (1 << YB);
      if (m_cmd == 'h2C) begin
        if (!m_have_hi) begin
          m_hi = b; m_have_hi = 1;
        end else begin
          e_kind = 2; e_x = m_px; e_y = m_py; e_d = m_hi * 256 + b; m_have_hi = 0;
          if (m_px == m_xe || m_px == XSZ - 1) begin
            m_px = m_xs;
            m_py = (m_py == m_ye || m_py == YSZ - 1) ? m_ys : (m_py + 1) % (1 << YB);
          end else begin
            m_px = (m_px + 1) % (1 << XB);
          end
        end
      end
      if (m_arg < 15) m_arg++;
    end
  endfunction

  task automatic spi_bit(input bit d, input bit dcv);
    @(negedge clk);
    spi_mosi = d; spi_dc = dcv; spi_clk = 1'b0;
    repeat (H) @(negedge clk);
    spi_clk = 1'b1;
    repeat (H - 1) @(negedge clk);
  endtask

  // mode 0: keep csn low after the byte, 1: raise csn afterwards,
  // 2: raise csn together with the 8th rising edge.
  task automatic xfer(input bit dc, input int b, input int mode);
    logic [7:0] bv;
    int lat;
    bv = 8'(b);
    m_byte(dc, b);
    got_cmd.delete(); got_pix.delete();
    if (spi_csn) begin
      @(negedge clk); spi_csn = 1'b0;
      repeat (2) @(negedge clk);
    end
    for (int i = 7; i >= 1; i--) spi_bit(bv[i], dc);
    @(negedge clk);
    spi_mosi = bv[0]; spi_dc = dc; spi_clk = 1'b0;
    repeat (H) @(negedge clk);
    spi_clk = 1'b1;
    if (mode == 2) spi_csn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (cmd_valid || pix_we) begin lat = k; break; end
    end
    @(negedge clk); @(posedge clk);
    if (got_cmd.size() == 0 && got_pix.size() == 0) cap_kind = 0;
    else if (got_cmd.size() == 1 && got_pix.size() == 0) cap_kind = 1;
    else if (got_cmd.size() == 0 && got_pix.size() == 1) cap_kind = 2;
    else cap_kind = 3;
    chk("event_kind", cap_kind, e_kind);
    if (e_kind != 0) chk("latency", lat, 4);
    if (cap_kind == 1) begin
      cap_d = got_cmd[0];
      chk("cmd_byte", cap_d, e_d);
    end
    if (cap_kind == 2) begin
      cap_x = got_pix[0].x; cap_y = got_pix[0].y; cap_d = got_pix[0].d;
      chk("pix_x", cap_x, e_x);
      chk("pix_y", cap_y, e_y);
      chk("pix_data", cap_d, e_d);
    end
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      spi_csn = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  typedef struct { bit dc; int b; int kind; int ex; int ey; int ed; } vec_t;
  vec_t tbl[$];
  int   xa[7] = '{10, 11, 12, 10, 11, 12, 10};
  int   ya[7] = '{5, 5, 5, 6, 6, 6, 5};
  int   cmds[7] = '{'h2A, 'h2B, 'h2C, 'h01, 'h36, 'h3A, 'h00};

  initial begin
    m_reset(); m_px = 0; m_py = 0;
    #1;
    chk("reset_cmd_byte", cmd_byte, 0);
    chk("reset_pix_xy", {pix_x, pix_y}, 0);
    chk("reset_pix_data", pix_data, 0);
    chk("reset_pulses", {cmd_valid, pix_we}, 0);
    repeat (4) @(negedge clk);
    resn = 1'b1;
    repeat (4) @(negedge clk);

    tbl.push_back('{0, 'h2C, 1, 0, 0, 'h2C});
    tbl.push_back('{1, 'hF8, 0, 0, 0, 0});
    tbl.push_back('{1, 'h00, 2, 0, 0, 'hF800});
    tbl.push_back('{0, 'h2A, 1, 0, 0, 'h2A});
    tbl.push_back('{1, 'h00, 0, 0, 0, 0});
    tbl.push_back('{1, 'h0A, 0, 0, 0, 0});
    tbl.push_back('{1, 'h00, 0, 0, 0, 0});
    tbl.push_back('{1, 'h0C, 0, 0, 0, 0});
    tbl.push_back('{0, 'h2B, 1, 0, 0, 'h2B});
    tbl.push_back('{1, 'h00, 0, 0, 0, 0});
    tbl.push_back('{1, 'h05, 0, 0, 0, 0});
    tbl.push_back('{1, 'h00, 0, 0, 0, 0});
    tbl.push_back('{1, 'h06, 0, 0, 0, 0});
    tbl.push_back('{0, 'h2C, 1, 0, 0, 'h2C});
    for (int i = 0; i < 7; i++) begin
      tbl.push_back('{1, 'h30 + i, 0, 0, 0, 0});
      tbl.push_back('{1, 'h40 + i, 2, xa[i], ya[i], ('h30 + i) * 256 + 'h40 + i});
    end
    foreach (tbl[i]) begin
      xfer(tbl[i].dc, tbl[i].b, i % 2);
      chk("tbl_kind", cap_kind, tbl[i].kind);
      if (tbl[i].kind == 1) chk("tbl_cmd", cap_d, tbl[i].ed);
      if (tbl[i].kind == 2) begin
        chk("tbl_x", cap_x, tbl[i].ex);
        chk("tbl_y", cap_y, tbl[i].ey);
        chk("tbl_data", cap_d, tbl[i].ed);
      end
    end

    // csn rising with the 8th sample edge still completes the byte
    xfer(0, 'h2C, 0);
    xfer(1, 'h5A, 2);
    xfer(1, 'hA5, 2);
    chk("csn_edge_data", cap_d, 'h5AA5);

    // partial byte of 5 bits is discarded when csn rises
    xfer(0, 'h2C, 1);
    @(negedge clk); spi_csn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
    repeat (2) @(negedge clk); spi_csn = 1'b1;
    repeat (4) @(negedge clk);
    xfer(1, 'h12, 1);
    xfer(1, 'h34, 1);
    chk("partial_kind", cap_kind, 2);
    chk("partial_data", cap_d, 'h1234);

    // spi_resn pulse after CASET restores the full window
    xfer(0, 'h2A, 1);
    xfer(1, 'h00, 1); xfer(1, 'h03, 1); xfer(1, 'h00, 1); xfer(1, 'h05, 1);
    @(negedge clk); spi_resn = 1'b0;
    repeat (10) @(negedge clk); spi_resn = 1'b1;
    m_reset();
    repeat (6) @(negedge clk);
    xfer(0, 'h2C, 1); xfer(1, 'hBE, 1); xfer(1, 'hEF, 1);
    chk("softrst_x", cap_x, 0);
    chk("softrst_y", cap_y, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 15) begin
        xfer(0, cmds[$urandom_range(0, 6)], $urandom_range(0, 2));
      end else if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_arg < 4) begin
        xfer(1, (m_arg % 2 == 0) ? int'($urandom_range(0, 3) == 0) : int'($urandom_range(0, 20)),
             $urandom_range(0, 2));
      end else begin
        xfer(1, $urandom_range(0, 255), $urandom_range(0, 2));
      end
    end

    // free-running full frame, then wrap to the origin
    xfer(0, 'h01, 1);
    xfer(0, 'h2C, 0);
    for (int i = 0; i <= XSZ * YSZ; i++) begin
      xfer(1, ((i * 'h0123 + 'h0F0F) >> 8) & 'hFF, 0);
      xfer(1, (i * 'h0123 + 'h0F0F) & 'hFF, 0);
      if (i == XSZ * YSZ - 1) begin
        chk("frame_last_x", cap_x, XSZ - 1);
        chk("frame_last_y", cap_y, YSZ - 1);
        chk("frame_last_data", cap_d, (i * 'h0123 + 'h0F0F) & 'hFFFF);
      end
      if (i == XSZ * YSZ) begin
        chk("frame_wrap_x", cap_x, 0);
        chk("frame_wrap_y", cap_y, 0);
      end
    end

    // asynchronous reset between bits 3 and 4 of a byte
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
    @(negedge clk); resn = 1'b0;
    #1;
    chk("amid_cmd_byte", cmd_byte, 0);
    chk("amid_pix_xy", {pix_x, pix_y}, 0);
    chk("amid_pix_data", pix_data, 0);
    chk("amid_pulses", {cmd_valid, pix_we}, 0);
    spi_csn = 1'b1;
    repeat (3) @(negedge clk);
    resn = 1'b1;
    m_reset(); m_px = 0; m_py = 0;
    repeat (4) @(negedge clk);
    xfer(0, 'h2C, 1); xfer(1, 'hAB, 1); xfer(1, 'hCD, 1);
    chk("after_rst_data", cap_d, 'hABCD);
    chk("after_rst_xy", {cap_x[7:0], cap_y[7:0]}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/st7789_spi_rx.md
Name: st7789_spi_rx

Overview:
- SPI display-side receiver: decodes the 4-wire ST7789 write stream (csn, clk, mosi, dc, resn) produced by the team's LCD SPI driver cores.
- Emits decoded command strobes and addressed RGB pixel writes for a framebuffer or a simulation scoreboard.
- Used as a display emulator: HDMI mirror of the LCD, and loopback verification of the LCD video cores.
- Single system clock oversamples all SPI pins; no SPI-clock domain.

Parameters:
- c_x_size, 240, panel width in pixels
- c_y_size, 240, panel height in pixels
- c_x_bits, $clog2(c_x_size), pix_x width
- c_y_bits, $clog2(c_y_size), pix_y width
- c_color_bits, 16, pixel width; 16 means 2 bytes per pixel (RGB565, high byte first); below 12 means 1 byte per pixel
- c_clk_polarity, 1, spi_clk idle level; informational, not used for edge selection
- c_sample_rising, 1, 1: sample mosi/dc on the spi_clk rising edge; 0: sample on the falling edge

Ports:
- clk  in  1  system clock; must be at least 4x the spi_clk toggle frequency
- resn  in  1  asynchronous active-low reset
- spi_csn  in  1  chip select, active low
- spi_clk  in  1  SPI clock from the display driver
- spi_mosi  in  1  serial data, MSB first
- spi_dc  in  1  0 = command byte, 1 = argument or pixel data byte
- spi_resn  in  1  display hardware reset from the driver, active low
- cmd_valid  out  1  one-clk pulse when a command byte completes
- cmd_byte  out  8  last completed command byte
- pix_we  out  1  one-clk pulse when a pixel write is complete
- pix_x  out  c_x_bits  pixel column
- pix_y  out  c_y_bits  pixel row
- pix_data  out  c_color_bits  pixel value

Behaviour:
- Reset (resn=0, asynchronous): all outputs 0; sync flops 1 for csn/resn/clk (clk flops at c_clk_polarity); window xs=0, xe=c_x_size-1, ys=0, ye=c_y_size-1; cmd=0x00; arg_cnt=0; byte phase=0.
- Input conditioning: spi_csn, spi_clk, spi_mosi, spi_dc and spi_resn each pass through a 2-flop synchronizer.
- Edge detect: compare the sync output with one further delayed copy of spi_clk.
- Soft reset: synchronized spi_resn=0 restores the window, cmd, arg_cnt and phase to reset values. pix_*/cmd_byte outputs hold.
- Bit capture: on a sample edge while csn=0, shift mosi into an 8-bit shift register and increment a 3-bit bit counter. dc is captured at the 8th bit.
- csn=1: clears the bit counter and discards any partial byte. Byte phase and arg_cnt are kept, because the driver drops csn between command, argument and delay bytes.
- Byte complete (8th bit) = internal byte strobe, one clk after the edge detect:
  - dc=0: cmd <= byte; arg_cnt <= 0; cmd_valid pulse with cmd_byte = byte. For 0x2C (RAMWR): ptr <= (xs, ys), phase <= 0. For 0x01 (SWRESET): window restored.
  - dc=1 and cmd=0x2A (CASET): arg 0..3 = XS_hi, XS_lo, XE_hi, XE_lo. xs/xe take the low c_x_bits of the 16-bit values, committed when the respective lo byte arrives. Args beyond 3 are ignored.
  - dc=1 and cmd=0x2B (RASET): same scheme as CASET for ys/ye.
  - dc=1 and cmd=0x2C (RAMWR), c_color_bits>=12: phase 0 latches the high byte. Phase 1 forms the pixel, pulses pix_we with the current ptr, then advances ptr.
  - dc=1 and cmd=0x2C (RAMWR), c_color_bits<12: every byte is one pixel.
  - dc=1, any other cmd: arguments ignored; only arg_cnt increments, saturating at 15.
- Pointer advance:
  - If x==xe or x==c_x_size-1, then x <= xs and y advances. Otherwise x <= x+1.
  - y advance: if y==ye or y==c_y_size-1, then y <= ys. Otherwise y <= y+1.
  - This gives a free-running wrap for continuous frame streaming.
- Latency: pix_we and cmd_valid assert exactly 4 clk after the pin-level sampling spi_clk edge (2 sync + 1 edge detect + 1 output register).
- Simultaneous events:
  - csn rising in the same clk as the 8th sample edge: the byte completes.
  - resn and spi_resn assertion override everything.
  - A dc=0 byte mid-pixel discards the latched high byte.

Decomposition:
- Shared package st7789_pkg: command constants (NOP 0x00, SWRESET 0x01, CASET 0x2A, RASET 0x2B, RAMWR 0x2C, MADCTL 0x36, COLMOD 0x3A). The LCD video driver and its init-file generator reuse the same package.
- One sub-module spi_byte_rx: synchronizers, edge detect, bit counter and shift register. Outputs byte strobe, byte value and dc.
- Command/pixel decode stays in st7789_spi_rx.

Test Plan:
- Reset, then SPI mode 3: send cmd 0x2C followed by data 0xF8,0x00 -> one cmd_valid (cmd_byte=0x2C), then pix_we with x=0, y=0, data=0xF800.
- CASET 0x00,0x0A,0x00,0x0C, RASET 0x00,0x05,0x00,0x06, RAMWR, then 7 pixels -> addresses (10,5),(11,5),(12,5),(10,6),(11,6),(12,6),(10,5).
- Full 240x240 frame of 57600 pixels from the LCD video driver (free-running mode) -> last write at (239,239); next write at (0,0); pix_data matches a driver-side pattern.
- csn raised after 5 bits of a data byte, then a full byte 0x12,0x34 -> partial byte discarded; pix_data=0x1234.
- Pulse spi_resn low mid-frame after CASET -> window returns to 0..239; next RAMWR pixel lands at (0,0).
- resn asserted between bits 3 and 4 -> all outputs 0 immediately; first byte after release is decoded correctly.
